// File: rtl/fifo_prog_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_prog_pkg : read-mode constants and depth helper for fifo_prog
// Rev 1.0
// ------------------------------------------------------------------
package fifo_prog_pkg;

  localparam string SHOWAHEAD_ON  = "ON";
  localparam string SHOWAHEAD_OFF = "OFF";

  function automatic int unsigned fifo_depth(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_prog_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_prog_ram : simple dual-port RAM, one write port, registered read address
// Rev 1.0
// ------------------------------------------------------------------
module fifo_prog_ram
  import fifo_prog_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(AWIDTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] raddr_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule
`default_nettype wire

// File: rtl/fifo_prog.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_prog : single-clock FIFO with run-time thresholds and sticky errors
// Rev 1.0
// ------------------------------------------------------------------
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int    DWIDTH    = 16,
  parameter int    AWIDTH    = 8,
  parameter string SHOWAHEAD = "ON"
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic [AWIDTH:0]   afull_thr_i,
  input  logic [AWIDTH:0]   aempty_thr_i,
  input  logic              clr_err_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned   DEPTH      = fifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] ONE      = (AWIDTH+1)'(1);
  localparam bit            SHOW_AHEAD = (SHOWAHEAD == SHOWAHEAD_ON);

  logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_fire_q, rd_fire_d;
  logic [DWIDTH-1:0] q_hold_q, q_hold_d;
  logic              wr_acc, rd_acc, show_live;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] ram_q;

  assign empty_o        = (usedw_q == '0);
  assign full_o         = (usedw_q == FULL_CNT);
  assign usedw_o        = usedw_q;
  assign almost_full_o  = (usedw_q >= afull_thr_i);
  assign almost_empty_o = (usedw_q <  aempty_thr_i);
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign wr_acc         = wrreq_i && !full_o && !srst_i;
  assign rd_acc         = rdreq_i && !empty_o && !srst_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    rd_fire_d = 1'b0;
    q_hold_d  = q_o;
    if (srst_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      q_hold_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + ONE;
        2'b01:   usedw_d = usedw_q - ONE;
        default: usedw_d = usedw_q;
      endcase
      // a new error event beats a simultaneous clear
      if (clr_err_i) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (wrreq_i && full_o)  ovf_d = 1'b1;
      if (rdreq_i && empty_o) udf_d = 1'b1;
      rd_fire_d = rd_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_ptr_q  <= wr_ptr_d;
    rd_ptr_q  <= rd_ptr_d;
    usedw_q   <= usedw_d;
    ovf_q     <= ovf_d;
    udf_q     <= udf_d;
    rd_fire_q <= rd_fire_d;
    q_hold_q  <= q_hold_d;
  end

  // Show-ahead tracks the upcoming head; normal mode fetches the word being read.
  generate
    if (SHOW_AHEAD) begin : g_showahead
      assign rd_addr   = rd_ptr_d[AWIDTH-1:0];
      assign show_live = !empty_o;
    end else begin : g_normal
      assign rd_addr   = rd_ptr_q[AWIDTH-1:0];
      assign show_live = rd_fire_q;
    end
  endgenerate

  assign q_o = show_live ? ram_q : q_hold_q;

  fifo_prog_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AWIDTH-1:0]),
    .wdata_i (data_i),
    .raddr_i (rd_addr),
    .rdata_o (ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_prog.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fifo_prog : self-checking bench, show-ahead and normal instances vs queue model
// Rev 1.0
// ------------------------------------------------------------------
module tb_fifo_prog;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          srst, wrreq, rdreq, clr_err;
  logic [DW-1:0] data;
  logic [AW:0]   afull_thr, aempty_thr;

  logic [DW-1:0] q_on, q_off;
  logic          empty_on, full_on, af_on, ae_on, ovf_on, udf_on;
  logic          empty_off, full_off, af_off, ae_off, ovf_off, udf_off;
  logic [AW:0]   usedw_on, usedw_off;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_qon, m_qoff;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("ON")) dut_on (
    .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr), .clr_err_i(clr_err),
    .q_o(q_on), .empty_o(empty_on), .full_o(full_on), .usedw_o(usedw_on),
    .almost_full_o(af_on), .almost_empty_o(ae_on),
    .overflow_o(ovf_on), .underflow_o(udf_on)
  );

  fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("OFF")) dut_off (
    .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr), .clr_err_i(clr_err),
    .q_o(q_off), .empty_o(empty_off), .full_o(full_off), .usedw_o(usedw_off),
    .almost_full_o(af_off), .almost_empty_o(ae_off),
    .overflow_o(ovf_off), .underflow_o(udf_off)
  );

  // One clock of stimulus; the model advances with the same request.
  task automatic cycle(input bit wr, input bit rd, input logic [DW-1:0] d,
                       input bit clr, input bit rst);
    bit mfull, memp;
    srst = rst; wrreq = wr; rdreq = rd; data = d; clr_err = clr;
    @(posedge clk);
    mfull = (mq.size() == DEPTH);
    memp  = (mq.size() == 0);
    if (rst) begin
      mq.delete(); m_ovf = 0; m_udf = 0; m_qon = '0; m_qoff = '0;
    end else begin
      if (wr && mfull) m_ovf = 1; else if (clr) m_ovf = 0;
      if (rd && memp)  m_udf = 1; else if (clr) m_udf = 0;
      if (rd && !memp) m_qoff = mq.pop_front();
      if (wr && !mfull) mq.push_back(d);
      if (mq.size() != 0) m_qon = mq[0];
    end
    #1;
    srst = 0; wrreq = 0; rdreq = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    cycle(0, 0, '0, 0, 1);
    checks++; if (usedw_on !== 4'd0) begin errors++; $display("FAIL reset_usedw actual=%0d expected=0", usedw_on); end
    checks++; if (empty_on !== 1'b1) begin errors++; $display("FAIL reset_empty actual=%b expected=1", empty_on); end
    checks++; if (full_on !== 1'b0) begin errors++; $display("FAIL reset_full actual=%b expected=0", full_on); end
    checks++; if (q_on !== 16'h0) begin errors++; $display("FAIL reset_q_on actual=%h expected=0000", q_on); end
    checks++; if (q_off !== 16'h0) begin errors++; $display("FAIL reset_q_off actual=%h expected=0000", q_off); end
    checks++; if ({ovf_on, udf_on} !== 2'b00) begin errors++; $display("FAIL reset_flags actual=%b expected=00", {ovf_on, udf_on}); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) cycle(1, 0, 16'(i), 0, 0);
    checks++; if (full_on !== 1'b1) begin errors++; $display("FAIL fill_full actual=%b expected=1", full_on); end
    checks++; if (usedw_on !== 4'd8) begin errors++; $display("FAIL fill_usedw actual=%0d expected=8", usedw_on); end
    checks++; if (q_on !== 16'd1) begin errors++; $display("FAIL fill_q_on actual=%h expected=0001", q_on); end
    cycle(1, 0, 16'd9, 0, 0);
    checks++; if (ovf_on !== 1'b1) begin errors++; $display("FAIL overflow_set actual=%b expected=1", ovf_on); end
    checks++; if (usedw_on !== 4'd8) begin errors++; $display("FAIL overflow_usedw actual=%0d expected=8", usedw_on); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 8; i++) begin
      checks++; if (q_on !== 16'(i)) begin errors++; $display("FAIL drain_q_on[%0d] actual=%h expected=%h", i, q_on, 16'(i)); end
      cycle(0, 1, '0, 0, 0);
      checks++; if (q_off !== 16'(i)) begin errors++; $display("FAIL drain_q_off[%0d] actual=%h expected=%h", i, q_off, 16'(i)); end
    end
    checks++; if (empty_on !== 1'b1) begin errors++; $display("FAIL drain_empty actual=%b expected=1", empty_on); end
    checks++; if (q_on !== 16'd8) begin errors++; $display("FAIL drain_q_on_hold actual=%h expected=0008", q_on); end
    cycle(0, 1, '0, 0, 0);
    checks++; if (udf_on !== 1'b1) begin errors++; $display("FAIL underflow_set actual=%b expected=1", udf_on); end
    cycle(0, 0, '0, 1, 0);
    checks++; if ({ovf_on, udf_on} !== 2'b00) begin errors++; $display("FAIL clr_err actual=%b expected=00", {ovf_on, udf_on}); end
  endtask

  task automatic test_normal_mode();
    cycle(1, 0, 16'hA5, 0, 0);
    checks++; if (q_off !== 16'd8) begin errors++; $display("FAIL normal_hold actual=%h expected=0008", q_off); end
    cycle(0, 1, '0, 0, 0);
    checks++; if (q_off !== 16'hA5) begin errors++; $display("FAIL normal_read actual=%h expected=00a5", q_off); end
    cycle(0, 0, '0, 0, 0);
    checks++; if (q_off !== 16'hA5) begin errors++; $display("FAIL normal_stable actual=%h expected=00a5", q_off); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cycle(1, 0, 16'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 16'($urandom), 0, 0);
      checks++; if (usedw_on !== 4'd4) begin errors++; $display("FAIL b2b_usedw[%0d] actual=%0d expected=4", i, usedw_on); end
      checks++; if (q_off !== m_qoff) begin errors++; $display("FAIL b2b_q_off[%0d] actual=%h expected=%h", i, q_off, m_qoff); end
      checks++; if (q_on !== m_qon) begin errors++; $display("FAIL b2b_q_on[%0d] actual=%h expected=%h", i, q_on, m_qon); end
    end
  endtask

  task automatic test_thresholds();
    cycle(0, 0, '0, 0, 1);
    afull_thr = 4'd6; aempty_thr = 4'd2;
    for (int i = 0; i <= 8; i++) begin
      #1;
      checks++; if (ae_on !== (i < 2)) begin errors++; $display("FAIL aempty[%0d] actual=%b expected=%b", i, ae_on, (i < 2)); end
      checks++; if (af_on !== (i >= 6)) begin errors++; $display("FAIL afull[%0d] actual=%b expected=%b", i, af_on, (i >= 6)); end
      if (i < 8) cycle(1, 0, 16'(i), 0, 0);
    end
    afull_thr = 4'd9; aempty_thr = 4'd9;
    #1;
    checks++; if (af_on !== 1'b0) begin errors++; $display("FAIL afull_thr_change actual=%b expected=0", af_on); end
    checks++; if (ae_on !== 1'b1) begin errors++; $display("FAIL aempty_thr_change actual=%b expected=1", ae_on); end
    afull_thr = 4'd6; aempty_thr = 4'd2;
  endtask

  task automatic test_reset_midop();
    cycle(0, 0, '0, 0, 1);
    cycle(0, 1, '0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 16'($urandom), 0, 0);
    checks++; if (usedw_on !== 4'd5 || udf_on !== 1'b1) begin errors++; $display("FAIL midop_pre actual=%0d/%b expected=5/1", usedw_on, udf_on); end
    cycle(1, 0, 16'h1234, 0, 1);
    checks++; if (usedw_on !== 4'd0 || empty_on !== 1'b1) begin errors++; $display("FAIL midop_count actual=%0d/%b expected=0/1", usedw_on, empty_on); end
    checks++; if (q_on !== 16'h0 || q_off !== 16'h0) begin errors++; $display("FAIL midop_q actual=%h/%h expected=0000/0000", q_on, q_off); end
    checks++; if ({ovf_on, udf_on} !== 2'b00) begin errors++; $display("FAIL midop_flags actual=%b expected=00", {ovf_on, udf_on}); end
  endtask

  task automatic test_random();
    bit wr, rd, clr, rst;
    int pwr;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) begin
        afull_thr  = 4'($urandom_range(0, 9));
        aempty_thr = 4'($urandom_range(0, 9));
      end
      pwr = ((k / 40) % 2 == 0) ? 75 : 25;
      wr  = ($urandom % 100) < pwr;
      rd  = ($urandom % 100) < (100 - pwr);
      clr = ($urandom % 20) == 0;
      rst = ($urandom % 150) == 0;
      cycle(wr, rd, 16'($urandom), clr, rst);
      checks++; if (usedw_on !== 4'(mq.size()) || usedw_off !== 4'(mq.size())) begin errors++; $display("FAIL rnd_usedw[%0d] actual=%0d/%0d expected=%0d", k, usedw_on, usedw_off, mq.size()); end
      checks++; if (empty_on !== (mq.size() == 0) || full_on !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_empty_full[%0d] actual=%b%b expected=%b%b", k, empty_on, full_on, (mq.size() == 0), (mq.size() == DEPTH)); end
      checks++; if (q_on !== m_qon) begin errors++; $display("FAIL rnd_q_on[%0d] actual=%h expected=%h", k, q_on, m_qon); end
      checks++; if (q_off !== m_qoff) begin errors++; $display("FAIL rnd_q_off[%0d] actual=%h expected=%h", k, q_off, m_qoff); end
      checks++; if (ovf_on !== m_ovf || udf_on !== m_udf) begin errors++; $display("FAIL rnd_flags[%0d] actual=%b%b expected=%b%b", k, ovf_on, udf_on, m_ovf, m_udf); end
      checks++; if (af_on !== (mq.size() >= int'(afull_thr)) || ae_on !== (mq.size() < int'(aempty_thr))) begin errors++; $display("FAIL rnd_thr[%0d] actual=%b%b expected=%b%b", k, af_on, ae_on, (mq.size() >= int'(afull_thr)), (mq.size() < int'(aempty_thr))); end
    end
  endtask

  initial begin
    srst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; clr_err = 1'b0; data = '0;
    afull_thr = 4'd6; aempty_thr = 4'd2;
    m_ovf = 0; m_udf = 0; m_qon = '0; m_qoff = '0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_normal_mode();
    test_back_to_back();
    test_thresholds();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 8, meaning log2 of depth (depth = 2**AWIDTH words).
REQ-003 The block SHALL have parameter SHOWAHEAD, default "ON", meaning read mode: "ON" = show-ahead (q_o presents head word), "OFF" = normal (q_o updates after read).
REQ-004 The block SHALL have the ports listed in REQ-005 to REQ-019.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 srst_i  input  1  reset, synchronous, active-high.
REQ-007 data_i  input  DWIDTH  write data.
REQ-008 wrreq_i  input  1  write request.
REQ-009 rdreq_i  input  1  read request / acknowledge.
REQ-010 afull_thr_i  input  AWIDTH+1  run-time almost-full threshold.
REQ-011 aempty_thr_i  input  AWIDTH+1  run-time almost-empty threshold.
REQ-012 clr_err_i  input  1  clears sticky error flags.
REQ-013 q_o  output  DWIDTH  read data.
REQ-014 empty_o  output  1  FIFO holds zero words.
REQ-015 full_o  output  1  FIFO holds 2**AWIDTH words.
REQ-016 usedw_o  output  AWIDTH+1  stored word count, 0..2**AWIDTH.
REQ-017 almost_full_o / almost_empty_o  output  1 each  threshold flags.
REQ-018 overflow_o  output  1  sticky: write attempted while full.
REQ-019 underflow_o  output  1  sticky: read attempted while empty.

Function
REQ-020 A write SHALL be accepted iff wrreq_i=1 and full_o=0; a read SHALL be accepted iff rdreq_i=1 and empty_o=0.
REQ-021 Write and read pointers SHALL be AWIDTH+1 bits, increment by 1 per accepted op, wrap modulo 2**(AWIDTH+1); memory indexed by low AWIDTH bits.
REQ-022 Memory SHALL be written only on an accepted write; rejected writes SHALL not modify memory or pointers.
REQ-023 usedw_o SHALL be registered: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read or no op.
REQ-024 empty_o SHALL equal (usedw_o==0); full_o SHALL equal (usedw_o==2**AWIDTH); both derived from registered state, no combinational path from inputs.
REQ-025 Simultaneous wrreq_i and rdreq_i when empty: only write accepted; when full: only read accepted, next cycle usedw_o=2**AWIDTH-1.
REQ-026 SHOWAHEAD="OFF": q_o SHALL present the head word 1 cycle after an accepted read and hold otherwise.
REQ-027 SHOWAHEAD="ON": whenever empty_o=0, q_o SHALL present the head word; after an accepted read q_o SHALL present the next word on the following cycle; when empty q_o holds its last value.
REQ-028 SHOWAHEAD="ON": a word written into an empty FIFO SHALL be on q_o in the same cycle empty_o first deasserts (1 cycle after the write).
REQ-029 almost_full_o SHALL be 1 iff usedw_o >= afull_thr_i; almost_empty_o SHALL be 1 iff usedw_o < aempty_thr_i; unsigned compare, combinational from usedw_o and threshold, threshold changes take effect immediately.
REQ-030 overflow_o SHALL set on wrreq_i=1 while full_o=1; underflow_o SHALL set on rdreq_i=1 while empty_o=1; both hold until clr_err_i=1; set SHALL win over simultaneous clear.

Reset
REQ-031 On srst_i=1 at a clock edge: pointers=0, usedw_o=0, empty_o=1, full_o=0, q_o=0, overflow_o=0, underflow_o=0; requests in that cycle are ignored.
REQ-032 Memory contents SHALL not be reset; reset mid-operation SHALL discard all stored words.

Structure
REQ-033 Package fifo_prog_pkg SHALL hold mode string constants ("ON"/"OFF") and a function computing depth from AWIDTH.
REQ-034 Storage SHALL be a sub-module fifo_prog_ram: simple dual-port, one write port, one registered-address read port, DWIDTH x 2**AWIDTH, inferable as block RAM.

Verification
REQ-035 AWIDTH=3, SHOWAHEAD="ON": write 1..8 -> full_o=1 after 8th, usedw_o=8, q_o=1; 9th write -> overflow_o=1, memory unchanged.
REQ-036 Read 8 words from full -> q_o sequence 1..8, empty_o=1 after last; extra rdreq -> underflow_o=1; clr_err_i -> both flags 0.
REQ-037 SHOWAHEAD="OFF", write 0xA5 then read -> q_o=0xA5 exactly 1 cycle after read accepted.
REQ-038 Simultaneous wr/rd at usedw_o=4 for 20 cycles (pointer wrap) -> usedw_o stays 4, data order preserved.
REQ-039 afull_thr_i=6, aempty_thr_i=2: fill 0->8 -> almost_empty_o=1 at usedw 0,1; almost_full_o=1 at usedw>=6.
REQ-040 srst_i asserted at usedw_o=5 with wrreq_i=1 -> next cycle usedw_o=0, empty_o=1, q_o=0, flags 0.
